// File: rtl/servo_pkg.sv
// Shared definitions for the servo jog controller.
// Holds the ceillog2 helper, the jog FSM state encoding and the default joint-index width.
// Contents: ceillog2(), jog_state_t, N_JOINTS_DFLT, JOINT_W.
package servo_pkg;

  // Smallest r such that 2**r >= value; returns 0 for value <= 1.
  function automatic int ceillog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  localparam int N_JOINTS_DFLT = 4;
  localparam int JOINT_W       = (N_JOINTS_DFLT > 1) ? ceillog2(N_JOINTS_DFLT) : 1;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_HOLD_WAIT = 2'd1,
    S_REPEAT    = 2'd2
  } jog_state_t;

endpackage

// File: rtl/servo_jog_controller_jog_timer.sv
// Loadable down-counter used to pace hold-delay and auto-repeat steps.
// Latency: load takes effect at the next clock; zero is combinational from the count.
// No backpressure: counts down every cycle until it reaches zero, then holds.
// Ports: clk, rst_a_p (async, active-high), load, load_val[W-1:0], zero.
module jog_timer #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_a_p,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      r_cnt <= '0;
    end else if (load) begin
      r_cnt <= load_val;
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign zero = (r_cnt == '0);

endmodule

// File: rtl/servo_jog_controller.sv
// Button-driven jog controller: steps the selected servo duty register, with hold auto-repeat.
// Latency: duty updates on the first sampling edge of a press; update_pulse follows one cycle later.
// No backpressure: buttons are levels sampled every cycle; duties saturate at DUTY_MIN/DUTY_MAX.
// Ports: clk, rst_a_p, btn_up, btn_down, btn_sel (inputs); sel_joint, duty_out, update_pulse (outputs).
module servo_jog_controller
  import servo_pkg::*;
#(
  parameter int N_JOINTS   = N_JOINTS_DFLT,
  parameter int DUTY_W     = 12,
  parameter int DUTY_MIN   = 100,
  parameter int DUTY_MAX   = 500,
  parameter int DUTY_RST   = 300,
  parameter int STEP       = 5,
  parameter int HOLD_CYC   = 50000,
  parameter int REPEAT_CYC = 10000,
  localparam int SEL_W     = (N_JOINTS > 1) ? ceillog2(N_JOINTS) : 1,
  localparam int TMR_RAW   = ceillog2((HOLD_CYC > REPEAT_CYC) ? HOLD_CYC : REPEAT_CYC),
  localparam int TMR_W     = (TMR_RAW > 0) ? TMR_RAW : 1
) (
  input  logic                       clk,
  input  logic                       rst_a_p,
  input  logic                       btn_up,
  input  logic                       btn_down,
  input  logic                       btn_sel,
  output logic [SEL_W-1:0]           sel_joint,
  output logic [N_JOINTS*DUTY_W-1:0] duty_out,
  output logic                       update_pulse
);

  localparam logic signed [DUTY_W:0] STEP_S = (DUTY_W+1)'(STEP);
  localparam logic signed [DUTY_W:0] MAX_S  = (DUTY_W+1)'(DUTY_MAX);
  localparam logic signed [DUTY_W:0] MIN_S  = (DUTY_W+1)'(DUTY_MIN);

  jog_state_t        r_state;
  logic              r_up_prev;
  logic              r_down_prev;
  logic              r_sel_prev;
  logic              r_dir_up;
  logic [SEL_W-1:0]  r_sel;
  logic [DUTY_W-1:0] r_duty [N_JOINTS];
  logic              r_changed;
  logic              r_pulse;

  logic              w_dir_vld;
  logic              w_dir_up;
  logic              w_dir_edge;
  logic              w_sel_edge;
  logic              w_release;
  logic              w_tmr_zero;
  logic              w_do_step;
  logic [TMR_W-1:0]  w_tmr_val;
  logic [DUTY_W-1:0] w_cur;
  logic signed [DUTY_W:0] w_sum;
  logic [DUTY_W-1:0] w_next;

  // A direction exists only when exactly one of up/down is high.
  assign w_dir_vld  = btn_up ^ btn_down;
  assign w_dir_up   = btn_up;
  // Rising edge of the active button only; releasing one of two held buttons is not an edge.
  assign w_dir_edge = w_dir_vld && (btn_up ? !r_up_prev : !r_down_prev);
  assign w_sel_edge = btn_sel && !r_sel_prev;
  assign w_release  = !w_dir_vld || (w_dir_up != r_dir_up);

  always_comb begin
    w_do_step = 1'b0;
    case (r_state)
      S_IDLE:                w_do_step = w_dir_edge;
      S_HOLD_WAIT, S_REPEAT: w_do_step = !w_release && w_tmr_zero;
      default:               w_do_step = 1'b0;
    endcase
  end

  assign w_tmr_val = (r_state == S_IDLE) ? TMR_W'(HOLD_CYC - 1) : TMR_W'(REPEAT_CYC - 1);

  jog_timer #(.W(TMR_W)) u_jog_timer (
    .clk      (clk),
    .rst_a_p  (rst_a_p),
    .load     (w_do_step),
    .load_val (w_tmr_val),
    .zero     (w_tmr_zero)
  );

  // Step arithmetic is one bit wider and signed so a down step near zero cannot wrap.
  assign w_cur = r_duty[r_sel];
  assign w_sum = $signed({1'b0, w_cur}) + (w_dir_up ? STEP_S : -STEP_S);

  always_comb begin
    w_next = w_sum[DUTY_W-1:0];
    if (w_sum > MAX_S) begin
      w_next = DUTY_W'(DUTY_MAX);
    end else if (w_sum < MIN_S) begin
      w_next = DUTY_W'(DUTY_MIN);
    end
  end

  always_ff @(posedge clk or posedge rst_a_p) begin
    if (rst_a_p) begin
      r_state     <= S_IDLE;
      r_up_prev   <= 1'b0;
      r_down_prev <= 1'b0;
      r_sel_prev  <= 1'b0;
      r_dir_up    <= 1'b0;
      r_sel       <= '0;
      r_changed   <= 1'b0;
      r_pulse     <= 1'b0;
      for (int j = 0; j < N_JOINTS; j++) begin
        r_duty[j] <= DUTY_W'(DUTY_RST);
      end
    end else begin
      r_up_prev   <= btn_up;
      r_down_prev <= btn_down;
      r_sel_prev  <= btn_sel;
      // The strobe trails the duty write by one cycle.
      r_pulse     <= r_changed;
      r_changed   <= 1'b0;
      if (w_do_step) begin
        r_duty[r_sel] <= w_next;
        r_changed     <= (w_next != w_cur);
      end
      case (r_state)
        S_IDLE: begin
          if (w_dir_edge) begin
            r_state  <= S_HOLD_WAIT;
            r_dir_up <= w_dir_up;
          end else if (w_sel_edge) begin
            r_sel <= (r_sel == SEL_W'(N_JOINTS - 1)) ? '0 : r_sel + 1'b1;
          end
        end
        S_HOLD_WAIT: begin
          if (w_release) begin
            r_state <= S_IDLE;
          end else if (w_tmr_zero) begin
            r_state <= S_REPEAT;
          end
        end
        S_REPEAT: begin
          if (w_release) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel_joint    = r_sel;
  assign update_pulse = r_pulse;

  always_comb begin
    duty_out = '0;
    for (int j = 0; j < N_JOINTS; j++) begin
      duty_out[j*DUTY_W +: DUTY_W] = r_duty[j];
    end
  end

endmodule
